// File: rtl/itype_exec_ctrl.sv
// itype_exec_ctrl: multi-cycle sequencer for RV32I OP-IMM instructions
// (ADDI, SLLI, XORI, SRLI, SRAI, ORI, ANDI). One instruction is accepted
// per handshake, rs1 is read from the register file, the shared ALU is
// driven with the operand and formatted immediate, and the result is
// written back to rd. Illegal encodings produce a one-cycle pulse.
module itype_exec_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             rf_rd_en,
    output logic [4:0]       rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic [2:0]       alu_op,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_imm,
    input  logic [XLEN-1:0]  alu_result,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] FUNC7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNC7_SRA  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SLL = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SRL = 3'd3;
    localparam logic [2:0] ALU_SRA = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_AND = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_ILL  = 3'd4
    } state_e;

    // True when the word is one of the supported OP-IMM encodings.
    function automatic logic decode_legal(input logic [31:0] ins);
        logic legal_v;
        legal_v = 1'b0;
        if (ins[6:0] == OPC_OP_IMM) begin
            case (ins[14:12])
                3'b000, 3'b100, 3'b110, 3'b111: legal_v = 1'b1;
                3'b001:  legal_v = (ins[31:25] == FUNC7_ZERO);
                3'b101:  legal_v = (ins[31:25] == FUNC7_ZERO) || (ins[31:25] == FUNC7_SRA);
                default: legal_v = 1'b0;
            endcase
        end else begin
            legal_v = 1'b0;
        end
        return legal_v;
    endfunction

    // ALU select for a legal encoding; func7 bit 5 separates SRA from SRL.
    function automatic logic [2:0] decode_op(input logic [2:0] f3, input logic [6:0] f7);
        logic [2:0] op_v;
        case (f3)
            3'b000:  op_v = ALU_ADD;
            3'b001:  op_v = ALU_SLL;
            3'b100:  op_v = ALU_XOR;
            3'b101:  op_v = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  op_v = ALU_OR;
            3'b111:  op_v = ALU_AND;
            default: op_v = ALU_ADD;
        endcase
        return op_v;
    endfunction

    // Shifts take a zero-extended 5-bit shamt; everything else sign-extends imm[11].
    function automatic logic [XLEN-1:0] format_imm(input logic [2:0] f3, input logic [11:0] imm);
        logic [XLEN-1:0] imm_v;
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
            imm_v = {{(XLEN-5){1'b0}}, imm[4:0]};
        end else begin
            imm_v = {{(XLEN-12){imm[11]}}, imm};
        end
        return imm_v;
    endfunction

    state_e           state_q, state_d;
    logic             accept_s;
    logic             legal_s;
    logic             rf_rd_en_q, rf_rd_en_d;
    logic [4:0]       rf_raddr_q, rf_raddr_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [XLEN-1:0]  alu_a_q, alu_a_d;
    logic [XLEN-1:0]  alu_imm_q, alu_imm_d;
    logic             rf_we_q, rf_we_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign instr_ready = (state_q == S_IDLE) && !reset;
    assign accept_s    = instr_valid && instr_ready;
    assign legal_s     = decode_legal(instr);

    // Next-state logic for the IDLE -> READ -> EXEC -> WB / IDLE -> ILL sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = legal_s ? S_READ : S_ILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ILL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and strobe next values; decoded fields hold until the next legal accept.
    always_comb begin
        rf_rd_en_d  = 1'b0;
        rf_we_d     = 1'b0;
        illegal_d   = 1'b0;
        rf_raddr_d  = rf_raddr_q;
        rf_waddr_d  = rf_waddr_q;
        alu_op_d    = alu_op_q;
        alu_imm_d   = alu_imm_q;
        alu_a_d     = alu_a_q;
        cnt_d       = cnt_q;
        if (accept_s && legal_s) begin
            rf_rd_en_d = 1'b1;
            rf_raddr_d = instr[19:15];
            rf_waddr_d = instr[11:7];
            alu_op_d   = decode_op(instr[14:12], instr[31:25]);
            alu_imm_d  = format_imm(instr[14:12], instr[31:20]);
        end else if (accept_s) begin
            illegal_d = 1'b1;
        end else begin
            rf_rd_en_d = 1'b0;
        end
        if (state_q == S_EXEC) begin
            // rf_rdata is valid this cycle because the read strobe was issued in READ.
            alu_a_d = rf_rdata;
            rf_we_d = (rf_waddr_q != 5'd0);
        end else begin
            rf_we_d = 1'b0;
        end
        if (state_q == S_WB) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers; synchronous reset drops any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rf_rd_en_q <= 1'b0;
            rf_raddr_q <= 5'd0;
            rf_waddr_q <= 5'd0;
            alu_op_q   <= 3'd0;
            alu_a_q    <= {XLEN{1'b0}};
            alu_imm_q  <= {XLEN{1'b0}};
            rf_we_q    <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rf_rd_en_q <= rf_rd_en_d;
            rf_raddr_q <= rf_raddr_d;
            rf_waddr_q <= rf_waddr_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_imm_q  <= alu_imm_d;
            rf_we_q    <= rf_we_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rf_rd_en    = rf_rd_en_q;
    assign rf_raddr    = rf_raddr_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_imm     = alu_imm_q;
    // A write in the same cycle as reset belongs to an aborted instruction.
    assign rf_we       = rf_we_q && !reset;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = (state_q == S_WB) ? alu_result : {XLEN{1'b0}};
    assign illegal     = illegal_q;
    assign busy        = (state_q != S_IDLE);
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_itype_exec_ctrl.sv
// Bench for itype_exec_ctrl: register file and ALU environment plus a
// spec-level reference model; directed and randomized scenarios.
module tb_itype_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready, rf_rd_en, rf_we, illegal, busy;
    logic [4:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, alu_a, alu_imm, alu_result, rf_wdata;
    logic [2:0]  alu_op;
    logic [15:0] retired_cnt;

    logic        r2_ready, r2_rd_en, r2_we, r2_illegal, r2_busy;
    logic [4:0]  r2_raddr, r2_waddr;
    logic [31:0] r2_a, r2_imm, r2_wdata;
    logic [2:0]  r2_op;
    logic [1:0]  r2_cnt;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_cnt;
    logic [31:0] regs [32];

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t wr_q[$];

    always #5 clk = ~clk;

    itype_exec_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_rd_en(rf_rd_en), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .alu_op(alu_op), .alu_a(alu_a), .alu_imm(alu_imm),
        .alu_result(alu_result), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .illegal(illegal), .busy(busy), .retired_cnt(retired_cnt)
    );

    // Narrow-counter copy fed identically, used to observe counter wrap.
    itype_exec_ctrl #(.XLEN(32), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(r2_ready), .rf_rd_en(r2_rd_en), .rf_raddr(r2_raddr),
        .rf_rdata(rf_rdata), .alu_op(r2_op), .alu_a(r2_a), .alu_imm(r2_imm),
        .alu_result(alu_result), .rf_we(r2_we), .rf_waddr(r2_waddr),
        .rf_wdata(r2_wdata), .illegal(r2_illegal), .busy(r2_busy), .retired_cnt(r2_cnt)
    );

    // Register file read port: data only valid the cycle after the strobe.
    always @(posedge clk) begin
        rf_rdata <= rf_rd_en ? regs[rf_raddr] : 32'hDEAD_BEEF;
    end

    // Shared ALU environment.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            3'd0: alu_result = alu_a + alu_imm;
            3'd1: alu_result = alu_a << alu_imm[4:0];
            3'd2: alu_result = alu_a ^ alu_imm;
            3'd3: alu_result = alu_a >> alu_imm[4:0];
            3'd4: alu_result = $signed(alu_a) >>> alu_imm[4:0];
            3'd5: alu_result = alu_a | alu_imm;
            3'd6: alu_result = alu_a & alu_imm;
            default: alu_result = 32'd0;
        endcase
    end

    // Record every write the register file would commit.
    always @(posedge clk) begin
        if (rf_we === 1'b1) wr_q.push_back('{a: rf_waddr, d: rf_wdata});
    end

    // Reference: what an OP-IMM instruction means, straight from the ISA rules.
    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                      output bit legal, output logic [2:0] op,
                                      output logic [31:0] imm, output logic [31:0] res);
        logic [31:0] simm;
        logic [4:0]  sh;
        simm  = 32'($signed(ins[31:20]));
        sh    = ins[24:20];
        legal = 1'b0; op = 3'd0; imm = 32'd0; res = 32'd0;
        if (ins[6:0] == 7'h13) begin
            case (ins[14:12])
                3'd0: begin legal = 1'b1; op = 3'd0; imm = simm; res = a + simm; end
                3'd4: begin legal = 1'b1; op = 3'd2; imm = simm; res = a ^ simm; end
                3'd6: begin legal = 1'b1; op = 3'd5; imm = simm; res = a | simm; end
                3'd7: begin legal = 1'b1; op = 3'd6; imm = simm; res = a & simm; end
                3'd1: if (ins[31:25] == 7'h00) begin
                    legal = 1'b1; op = 3'd1; imm = {27'd0, sh}; res = a << sh;
                end
                3'd5: if (ins[31:25] == 7'h00) begin
                    legal = 1'b1; op = 3'd3; imm = {27'd0, sh}; res = a >> sh;
                end else if (ins[31:25] == 7'h20) begin
                    legal = 1'b1; op = 3'd4; imm = {27'd0, sh}; res = 32'($signed(a) >>> sh);
                end
                default: legal = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [31:0] gen_legal();
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd;
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
        f7 = 7'($urandom);
        if (f3 == 3'd1) f7 = 7'h00;
        if (f3 == 3'd5) f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        rd = 5'($urandom_range(1, 31));
        return {f7, 5'($urandom), 5'($urandom), f3, rd, 7'h13};
    endfunction

    // One instruction through the full handshake, checking every cycle.
    task automatic exec_one(input logic [31:0] ins);
        bit          lg;
        logic [2:0]  eop;
        logic [31:0] eimm, eres, a;
        logic [4:0]  rs1, rd;
        rs1 = ins[19:15];
        rd  = ins[11:7];
        a   = regs[rs1];
        ref_model(ins, a, lg, eop, eimm, eres);
        n_total++;
        if (instr_ready !== 1'b1) $display("FAIL ready_at_accept: got %b want 1", instr_ready);
        else n_pass++;
        instr_valid = 1'b1;
        instr       = ins;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = $urandom;
        if (lg) begin
            n_total++;
            if ({rf_rd_en, rf_raddr, rf_we, illegal, busy, instr_ready} !== {1'b1, rs1, 1'b0, 1'b0, 1'b1, 1'b0})
                $display("FAIL read_cycle ins=%h: got %b want %b", ins,
                         {rf_rd_en, rf_raddr, rf_we, illegal, busy, instr_ready}, {1'b1, rs1, 4'b0010});
            else n_pass++;
            @(negedge clk);
            n_total++;
            if ({rf_rd_en, rf_we, illegal, busy, instr_ready} !== 5'b00010)
                $display("FAIL exec_cycle ins=%h: got %b want 00010", ins, {rf_rd_en, rf_we, illegal, busy, instr_ready});
            else n_pass++;
            @(negedge clk);
            n_total++;
            if ({alu_op, alu_imm, alu_a} !== {eop, eimm, a})
                $display("FAIL wb_alu ins=%h: got op=%0d imm=%h a=%h want op=%0d imm=%h a=%h",
                         ins, alu_op, alu_imm, alu_a, eop, eimm, a);
            else n_pass++;
            n_total++;
            if ({rf_we, rf_waddr, rf_wdata, rf_rd_en} !== {(rd != 5'd0), rd, eres, 1'b0})
                $display("FAIL wb_write ins=%h: got we=%b wa=%0d wd=%h want we=%b wa=%0d wd=%h",
                         ins, rf_we, rf_waddr, rf_wdata, (rd != 5'd0), rd, eres);
            else n_pass++;
            n_total++;
            if (retired_cnt !== exp_cnt) $display("FAIL cnt_in_wb: got %0d want %0d", retired_cnt, exp_cnt);
            else n_pass++;
            exp_cnt = exp_cnt + 16'd1;
            @(negedge clk);
            n_total++;
            if ({instr_ready, busy, rf_we, retired_cnt, r2_cnt} !== {3'b100, exp_cnt, exp_cnt[1:0]})
                $display("FAIL after_wb ins=%h: got rdy=%b busy=%b we=%b cnt=%0d cnt2=%0d want 1 0 0 %0d %0d",
                         ins, instr_ready, busy, rf_we, retired_cnt, r2_cnt, exp_cnt, exp_cnt[1:0]);
            else n_pass++;
        end else begin
            n_total++;
            if ({illegal, rf_rd_en, rf_we, busy, instr_ready} !== 5'b10010)
                $display("FAIL ill_pulse ins=%h: got %b want 10010", ins, {illegal, rf_rd_en, rf_we, busy, instr_ready});
            else n_pass++;
            @(negedge clk);
            n_total++;
            if ({illegal, rf_rd_en, rf_we, busy, instr_ready, retired_cnt} !== {5'b00001, exp_cnt})
                $display("FAIL ill_after ins=%h: got %b cnt=%0d want 00001 cnt=%0d", ins,
                         {illegal, rf_rd_en, rf_we, busy, instr_ready}, retired_cnt, exp_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr = 32'd0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({rf_rd_en, rf_we, illegal, busy, instr_ready, alu_op, rf_raddr, rf_waddr} !== 18'd0)
            $display("FAIL reset_ctl: got %b want 0", {rf_rd_en, rf_we, illegal, busy, instr_ready, alu_op, rf_raddr, rf_waddr});
        else n_pass++;
        n_total++;
        if ({alu_a, alu_imm, rf_wdata, retired_cnt} !== 112'd0)
            $display("FAIL reset_data: got %h want 0", {alu_a, alu_imm, rf_wdata, retired_cnt});
        else n_pass++;
        reset = 1'b0; exp_cnt = 16'd0;
        @(negedge clk);
        n_total++;
        if ({instr_ready, busy} !== 2'b10) $display("FAIL ready_after_reset: got %b want 10", {instr_ready, busy});
        else n_pass++;
    endtask

    task automatic test_addi();
        int base;
        base = wr_q.size();
        regs[1] = 32'h0000_0010;
        exec_one(32'hFFF0_8293);
        n_total++;
        if (wr_q.size() != base + 1) $display("FAIL addi_write_count: got %0d want %0d", wr_q.size() - base, 1);
        else if (wr_q[base].a !== 5'd5 || wr_q[base].d !== 32'h0000_000F)
            $display("FAIL addi_write: got x%0d=%h want x5=0000000f", wr_q[base].a, wr_q[base].d);
        else n_pass++;
        n_total++;
        if ({alu_op, alu_imm} !== {3'd0, 32'hFFFF_FFFF}) $display("FAIL addi_hold: got %0d %h want 0 ffffffff", alu_op, alu_imm);
        else n_pass++;
    endtask

    task automatic test_srai();
        int base;
        base = wr_q.size();
        regs[2] = 32'h8000_0000;
        exec_one(32'h4041_5193);
        n_total++;
        if (wr_q.size() != base + 1) $display("FAIL srai_write_count: got %0d want 1", wr_q.size() - base);
        else if (wr_q[base].a !== 5'd3 || wr_q[base].d !== 32'hF800_0000)
            $display("FAIL srai_write: got x%0d=%h want x3=f8000000", wr_q[base].a, wr_q[base].d);
        else n_pass++;
        n_total++;
        if ({alu_op, alu_imm} !== {3'd4, 32'h0000_0004}) $display("FAIL srai_hold: got %0d %h want 4 00000004", alu_op, alu_imm);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int base;
        base = wr_q.size();
        exec_one(32'h0200_9093);
        exec_one(32'h0200_90B3);
        exec_one(32'h0050_A093);
        exec_one(32'h0050_B093);
        n_total++;
        if (wr_q.size() != base) $display("FAIL illegal_no_write: got %0d writes want 0", wr_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_rd0();
        int base;
        base = wr_q.size();
        regs[1] = 32'h1234_0000;
        exec_one(32'h0050_E013);
        n_total++;
        if (wr_q.size() != base) $display("FAIL rd0_no_write: got %0d writes want 0", wr_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3];
        logic [31:0] eres [3];
        logic [2:0]  eop;
        logic [31:0] eimm;
        bit          lg;
        int          base;
        base = wr_q.size();
        for (int i = 0; i < 3; i++) begin
            ins[i] = gen_legal();
            ref_model(ins[i], regs[ins[i][19:15]], lg, eop, eimm, eres[i]);
        end
        for (int k = 0; k <= 12; k++) begin
            n_total++;
            if (instr_ready !== ((k % 4) == 0)) $display("FAIL b2b_ready k=%0d: got %b want %b", k, instr_ready, ((k % 4) == 0));
            else n_pass++;
            instr_valid = (k <= 8);
            instr       = ins[(k <= 8) ? (k / 4) : 2];
            @(negedge clk);
        end
        instr_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd3;
        n_total++;
        if (retired_cnt !== exp_cnt) $display("FAIL b2b_cnt: got %0d want %0d", retired_cnt, exp_cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (wr_q.size() <= base + i) $display("FAIL b2b_write%0d: got none want x%0d=%h", i, ins[i][11:7], eres[i]);
            else if (wr_q[base + i].a !== ins[i][11:7] || wr_q[base + i].d !== eres[i])
                $display("FAIL b2b_write%0d: got x%0d=%h want x%0d=%h", i, wr_q[base + i].a, wr_q[base + i].d, ins[i][11:7], eres[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = wr_q.size();
        regs[1] = $urandom;
        instr_valid = 1'b1; instr = 32'h0030_8393;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, rf_rd_en} !== 2'b10) $display("FAIL mid_exec_state: got %b want 10", {busy, rf_rd_en});
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rf_rd_en, rf_we, illegal, busy, instr_ready, alu_op, rf_raddr, rf_waddr} !== 18'd0)
            $display("FAIL mid_reset_ctl: got %b want 0", {rf_rd_en, rf_we, illegal, busy, instr_ready, alu_op, rf_raddr, rf_waddr});
        else n_pass++;
        n_total++;
        if ({alu_a, alu_imm, rf_wdata, retired_cnt} !== 112'd0)
            $display("FAIL mid_reset_data: got %h want 0", {alu_a, alu_imm, rf_wdata, retired_cnt});
        else n_pass++;
        reset = 1'b0; exp_cnt = 16'd0;
        @(negedge clk);
        n_total++;
        if ({instr_ready, busy} !== 2'b10) $display("FAIL mid_ready_after: got %b want 10", {instr_ready, busy});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (wr_q.size() != base || retired_cnt !== 16'd0)
            $display("FAIL mid_aborted: got writes=%0d cnt=%0d want 0 0", wr_q.size() - base, retired_cnt);
        else n_pass++;
        // Reset and handshake in the same cycle: the instruction is dropped.
        reset = 1'b1; instr_valid = 1'b1; instr = 32'h0030_8393;
        @(negedge clk);
        n_total++;
        if ({busy, rf_rd_en, illegal} !== 3'b000) $display("FAIL sim_reset: got %b want 000", {busy, rf_rd_en, illegal});
        else n_pass++;
        reset = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, instr_ready, rf_rd_en} !== 3'b010) $display("FAIL sim_dropped: got %b want 010", {busy, instr_ready, rf_rd_en});
        else n_pass++;
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; exp_cnt = 16'd0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exec_one(gen_legal());
        n_total++;
        if ({retired_cnt, r2_cnt} !== {16'd4, 2'd0}) $display("FAIL wrap: got %0d/%0d want 4/0", retired_cnt, r2_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        for (int t = 0; t < 40; t++) begin
            ins = gen_legal();
            case ($urandom_range(0, 5))
                0: ins[6:0] = 7'($urandom);
                1: ins[31:25] = 7'($urandom);
                2: ins[14:12] = 3'($urandom_range(2, 3));
                default: ins = ins;
            endcase
            if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
            exec_one(ins);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        exp_cnt = 16'd0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_srai();
        test_illegal();
        test_rd0();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
